// File: rtl/memory_slave_queue.sv
// Command-port bridge between a 32-bit processor I/O register and a memory-bus slave,
// with request/response FIFOs. Define MEMORY_SLAVE_QUEUE_IRQ_EN to add the irq output.
module memory_slave_queue #(
  parameter int DATA_WIDTH = 48,
  parameter int ADDR_WIDTH = 32,
  parameter int ID_WIDTH   = 8,
  parameter int REQ_DEPTH  = 4,
  parameter int RESP_DEPTH = 4
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [31:0]           in,
  output logic [31:0]           out,
  input  logic                  msValid,
  output logic                  msTaken,
  input  logic [ADDR_WIDTH-1:0] msAddress,
  input  logic [DATA_WIDTH-1:0] msData,
  input  logic [ID_WIDTH-1:0]   msID,
  input  logic                  msWrite,
  output logic                  smValid,
  input  logic                  smTaken,
  output logic [DATA_WIDTH-1:0] smData,
  output logic [ID_WIDTH-1:0]   smID
`ifdef MEMORY_SLAVE_QUEUE_IRQ_EN
  ,
  output logic                  irq
`endif
);

  typedef enum logic [7:0] {
    CMD_NONE        = 8'd0,
    CMD_DATA_LO     = 8'd1,
    CMD_DATA_HI     = 8'd2,
    CMD_MASTER_ID   = 8'd3,
    CMD_PUSH_RESP   = 8'd4,
    CMD_POP_REQ     = 8'd5,
    CMD_READ_ADDR   = 8'd6,
    CMD_READ_LO     = 8'd7,
    CMD_READ_HI     = 8'd8,
    CMD_READ_ID     = 8'd9,
    CMD_READ_WRITE  = 8'd10,
    CMD_STATUS      = 8'd11,
    CMD_CLEAR_ERR   = 8'd12
  } cmd_e;

  localparam int REQ_AW  = $clog2(REQ_DEPTH);
  localparam int RESP_AW = $clog2(RESP_DEPTH);
  localparam int LO_W    = (DATA_WIDTH < 24) ? DATA_WIDTH : 24;

  function automatic logic [7:0] sat8(input logic [31:0] c);
    return (c > 32'd255) ? 8'hFF : c[7:0];
  endfunction

  logic [31:0]           in_q, in_d;
  logic [DATA_WIDTH-1:0] stage_q, stage_d;
  logic [ID_WIDTH-1:0]   stage_id_q, stage_id_d;
  logic [REQ_AW:0]       req_wr_q, req_wr_d, req_rd_q, req_rd_d;
  logic [RESP_AW:0]      resp_wr_q, resp_wr_d, resp_rd_q, resp_rd_d;
  logic                  err_ov_q, err_ov_d, err_un_q, err_un_d;
  logic                  irq_bit;

  logic [ADDR_WIDTH-1:0] req_addr_mem  [REQ_DEPTH];
  logic [DATA_WIDTH-1:0] req_data_mem  [REQ_DEPTH];
  logic [ID_WIDTH-1:0]   req_id_mem    [REQ_DEPTH];
  logic                  req_write_mem [REQ_DEPTH];
  logic [DATA_WIDTH-1:0] resp_data_mem [RESP_DEPTH];
  logic [ID_WIDTH-1:0]   resp_id_mem   [RESP_DEPTH];

  logic [7:0]  cmd;
  logic [23:0] field;
  logic        act;
  logic        do_lo, do_hi, do_id, do_push, do_pop, do_clr;
  logic        req_full, req_empty, resp_full, resp_empty;
  logic        req_push, req_pop, resp_push, resp_pop;
  logic [REQ_AW:0]  req_count;
  logic [RESP_AW:0] resp_count;

  // Action commands fire only on the cycle the command word changes.
  assign cmd     = in[31:24];
  assign field   = in[23:0];
  assign act     = (in != in_q);
  assign do_lo   = act && (cmd == CMD_DATA_LO);
  assign do_hi   = act && (cmd == CMD_DATA_HI);
  assign do_id   = act && (cmd == CMD_MASTER_ID);
  assign do_push = act && (cmd == CMD_PUSH_RESP);
  assign do_pop  = act && (cmd == CMD_POP_REQ);
  assign do_clr  = act && (cmd == CMD_CLEAR_ERR);

  assign req_full   = (req_wr_q[REQ_AW-1:0] == req_rd_q[REQ_AW-1:0]) && (req_wr_q[REQ_AW] != req_rd_q[REQ_AW]);
  assign req_empty  = (req_wr_q == req_rd_q);
  assign resp_full  = (resp_wr_q[RESP_AW-1:0] == resp_rd_q[RESP_AW-1:0]) && (resp_wr_q[RESP_AW] != resp_rd_q[RESP_AW]);
  assign resp_empty = (resp_wr_q == resp_rd_q);
  assign req_count  = req_wr_q - req_rd_q;
  assign resp_count = resp_wr_q - resp_rd_q;

  assign msTaken   = !req_full;
  assign req_push  = msValid && !req_full;
  assign req_pop   = do_pop && !req_empty;
  assign resp_push = do_push && !resp_full;
  assign resp_pop  = !resp_empty && smTaken;

  assign smValid = !resp_empty;
  assign smData  = resp_data_mem[resp_rd_q[RESP_AW-1:0]];
  assign smID    = resp_id_mem[resp_rd_q[RESP_AW-1:0]];

  // NOTE: every variable gets a default at the top of always_comb so no path infers a latch.
  always_comb begin
    in_d       = in;
    stage_d    = stage_q;
    stage_id_d = stage_id_q;
    if (do_lo) for (int b = 0; b < LO_W; b++) stage_d[b] = field[b];
    if (do_hi) for (int b = 24; b < DATA_WIDTH; b++) stage_d[b] = field[b-24];
    if (do_id) stage_id_d = field[ID_WIDTH-1:0];
    req_wr_d  = req_wr_q + (REQ_AW+1)'(req_push);
    req_rd_d  = req_rd_q + (REQ_AW+1)'(req_pop);
    resp_wr_d = resp_wr_q + (RESP_AW+1)'(resp_push);
    resp_rd_d = resp_rd_q + (RESP_AW+1)'(resp_pop);
    // Clear first so an error event in the same cycle takes precedence.
    err_ov_d = do_clr ? 1'b0 : err_ov_q;
    err_un_d = do_clr ? 1'b0 : err_un_q;
    if (do_push && resp_full) err_ov_d = 1'b1;
    if (do_pop && req_empty)  err_un_d = 1'b1;
  end

`ifdef MEMORY_SLAVE_QUEUE_IRQ_EN
  logic irq_q, irq_d;
  always_comb begin
    irq_d = irq_q;
    if (do_clr && req_empty) irq_d = 1'b0;
    if (req_push || err_ov_d || err_un_d) irq_d = 1'b1;
  end
  always_ff @(posedge clock or posedge reset) begin
    if (reset) irq_q <= 1'b0;
    else       irq_q <= irq_d;
  end
  assign irq     = irq_q;
  assign irq_bit = irq_q;
`else
  assign irq_bit = 1'b0;
`endif

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      in_q       <= '0;
      stage_q    <= '0;
      stage_id_q <= '0;
      req_wr_q   <= '0;
      req_rd_q   <= '0;
      resp_wr_q  <= '0;
      resp_rd_q  <= '0;
      err_ov_q   <= 1'b0;
      err_un_q   <= 1'b0;
    end else begin
      in_q       <= in_d;
      stage_q    <= stage_d;
      stage_id_q <= stage_id_d;
      req_wr_q   <= req_wr_d;
      req_rd_q   <= req_rd_d;
      resp_wr_q  <= resp_wr_d;
      resp_rd_q  <= resp_rd_d;
      err_ov_q   <= err_ov_d;
      err_un_q   <= err_un_d;
    end
  end

  // NOTE: FIFO storage is not reset; the pointers alone define which entries are valid.
  always_ff @(posedge clock) begin
    if (req_push) begin
      req_addr_mem[req_wr_q[REQ_AW-1:0]]  <= msAddress;
      req_data_mem[req_wr_q[REQ_AW-1:0]]  <= msData;
      req_id_mem[req_wr_q[REQ_AW-1:0]]    <= msID;
      req_write_mem[req_wr_q[REQ_AW-1:0]] <= msWrite;
    end
    if (resp_push) begin
      resp_data_mem[resp_wr_q[RESP_AW-1:0]] <= stage_q;
      resp_id_mem[resp_wr_q[RESP_AW-1:0]]   <= stage_id_q;
    end
  end

  logic [DATA_WIDTH-1:0] head_data;
  logic [23:0]           head_lo, head_hi;

  assign head_data = req_data_mem[req_rd_q[REQ_AW-1:0]];

  always_comb begin
    head_lo = '0;
    head_hi = '0;
    for (int b = 0; b < LO_W; b++) head_lo[b] = head_data[b];
    for (int b = 24; b < DATA_WIDTH; b++) head_hi[b-24] = head_data[b];
    out = '0;
    case (cmd)
      CMD_READ_ADDR:  if (!req_empty) out = 32'(req_addr_mem[req_rd_q[REQ_AW-1:0]]);
      CMD_READ_LO:    if (!req_empty) out = 32'(head_lo);
      CMD_READ_HI:    if (!req_empty) out = 32'(head_hi);
      CMD_READ_ID:    if (!req_empty) out = 32'(req_id_mem[req_rd_q[REQ_AW-1:0]]);
      CMD_READ_WRITE: if (!req_empty) out = 32'(req_write_mem[req_rd_q[REQ_AW-1:0]]);
      CMD_STATUS:     out = {11'd0, irq_bit, err_un_q, err_ov_q, resp_full, req_full,
                             sat8(32'(resp_count)), sat8(32'(req_count))};
      default:        out = '0;
    endcase
  end

endmodule
